// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one downstream memory bus between the fetch port (ireq) and the data port (dreq).
// Latency : one arbitration cycle from IDLE to issue; completion is forwarded combinationally.
// Backpressure: requesters hold valid until their data_ok pulse; the loser waits in place.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   ireq_*  / iresp_*               fetch request fields in, completion pulse + read data out
//   dreq_*  / dresp_*               data request fields in (strobe 0 = load), completion + load data out
//   creq_*                          downstream request driven from the holding register
//   cresp_data_ok, cresp_data       downstream completion pulse and read data
//   grant                           current owner: 00 none, 01 fetch, 10 data
// Build option: define ARB_ROUND_ROBIN_EN to alternate the winner when both ports
// request together; otherwise the data port always wins over fetch.
module mem_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ireq_valid,
    input  logic [ADDR_W-1:0]     ireq_addr,
    input  logic [SIZE_W-1:0]     ireq_size,
    output logic                  iresp_data_ok,
    output logic [DATA_W-1:0]     iresp_data,
    input  logic                  dreq_valid,
    input  logic [ADDR_W-1:0]     dreq_addr,
    input  logic [SIZE_W-1:0]     dreq_size,
    input  logic [DATA_W/8-1:0]   dreq_strobe,
    input  logic [DATA_W-1:0]     dreq_data,
    output logic                  dresp_data_ok,
    output logic [DATA_W-1:0]     dresp_data,
    output logic                  creq_valid,
    output logic [ADDR_W-1:0]     creq_addr,
    output logic [SIZE_W-1:0]     creq_size,
    output logic [DATA_W/8-1:0]   creq_strobe,
    output logic [DATA_W-1:0]     creq_data,
    input  logic                  cresp_data_ok,
    input  logic [DATA_W-1:0]     cresp_data,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]   hold_addr;
    logic [SIZE_W-1:0]   hold_size;
    logic [DATA_W/8-1:0] hold_strobe;
    logic [DATA_W-1:0]   hold_data;

    logic any_req;
    logic pick_d;   // data port wins this arbitration

    assign any_req = ireq_valid | dreq_valid;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 = fetch won last, 1 = data won last; on a tie the other port goes next.
    logic last_owner;

    assign pick_d = dreq_valid & ~(ireq_valid & last_owner);

    always_ff @(posedge clk) begin
        if (reset)
            last_owner <= 1'b0;
        else if (state == IDLE && any_req)
            last_owner <= pick_d;
    end
`else
    // Older memory ops must never wait behind a fetch.
    assign pick_d = dreq_valid;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = pick_d ? BUSY_D : BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (cresp_data_ok)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holding register: captured on the grant edge so upstream changes during
    // the transaction never reach the bus. Fetches carry no store data.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_addr   <= '0;
            hold_size   <= '0;
            hold_strobe <= '0;
            hold_data   <= '0;
        end else if (state == IDLE && any_req) begin
            if (pick_d) begin
                hold_addr   <= dreq_addr;
                hold_size   <= dreq_size;
                hold_strobe <= dreq_strobe;
                hold_data   <= dreq_data;
            end else begin
                hold_addr   <= ireq_addr;
                hold_size   <= ireq_size;
                hold_strobe <= '0;
                hold_data   <= '0;
            end
        end
    end

    // Output logic. Completion in IDLE is spurious and never forwarded.
    always_comb begin
        creq_valid    = (state != IDLE);
        creq_addr     = hold_addr;
        creq_size     = hold_size;
        creq_strobe   = hold_strobe;
        creq_data     = hold_data;
        grant         = state;
        iresp_data_ok = (state == BUSY_I) & cresp_data_ok;
        dresp_data_ok = (state == BUSY_D) & cresp_data_ok;
        iresp_data    = iresp_data_ok ? cresp_data : '0;
        dresp_data    = dresp_data_ok ? cresp_data : '0;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose : randomized self-checking bench for mem_bus_arbiter with a transaction-level reference.
// Latency : checks one-cycle arbitration and same-cycle completion forwarding.
// Backpressure: requesters hold valid until their completion, as the bus protocol requires.
module tb_mem_bus_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = 3;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ireq_valid, dreq_valid;
    logic [AW-1:0] ireq_addr, dreq_addr;
    logic [SW-1:0] ireq_size, dreq_size;
    logic [BW-1:0] dreq_strobe;
    logic [DW-1:0] dreq_data;
    logic          iresp_data_ok, dresp_data_ok;
    logic [DW-1:0] iresp_data, dresp_data;
    logic          creq_valid;
    logic [AW-1:0] creq_addr;
    logic [SW-1:0] creq_size;
    logic [BW-1:0] creq_strobe;
    logic [DW-1:0] creq_data;
    logic          cresp_data_ok;
    logic [DW-1:0] cresp_data;
    logic [1:0]    grant;

    int total = 0;
    int bad   = 0;
    bit last_data = 1'b0;   // reference: did the data port win the last grant

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_size(ireq_size),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .creq_valid(creq_valid), .creq_addr(creq_addr), .creq_size(creq_size),
        .creq_strobe(creq_strobe), .creq_data(creq_data),
        .cresp_data_ok(cresp_data_ok), .cresp_data(cresp_data),
        .grant(grant)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Arbitration rule: 0 none, 1 fetch, 2 data.
    function automatic int pick();
        if (ireq_valid && dreq_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            return last_data ? 1 : 2;
`else
            return 2;
`endif
        end
        if (dreq_valid) return 2;
        if (ireq_valid) return 1;
        return 0;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_creq_valid"}, 64'(creq_valid), 64'd0);
        check({tag, "_iok"}, 64'(iresp_data_ok), 64'd0);
        check({tag, "_dok"}, 64'(dresp_data_ok), 64'd0);
    endtask

    // Entered #1 after a clock edge with the DUT idle and requests already driven.
    task automatic txn(input int waits, input logic [63:0] rdata, input bit mutate,
                       input logic [63:0] maddr, input bit drop, input bit abort);
        int            w;
        logic [AW-1:0] ea;
        logic [SW-1:0] es;
        logic [BW-1:0] est;
        logic [DW-1:0] ed;
        w = pick();
        if (w == 2) begin
            ea = dreq_addr; es = dreq_size; est = dreq_strobe; ed = dreq_data;
        end else begin
            ea = ireq_addr; es = ireq_size; est = '0; ed = '0;
        end
        @(negedge clk);
        check("arb_grant", 64'(grant), 64'd0);
        check("arb_creq_valid", 64'(creq_valid), 64'd0);
        @(posedge clk); #1;
        last_data = (w == 2);
        check("grant", 64'(grant), 64'(w));
        check("creq_valid", 64'(creq_valid), 64'd1);
        check("creq_addr", creq_addr, ea);
        check("creq_size", 64'(creq_size), 64'(es));
        check("creq_strobe", 64'(creq_strobe), 64'(est));
        check("creq_data", creq_data, ed);
        if (mutate) begin
            if (w == 2) dreq_addr = maddr; else ireq_addr = maddr;
            if (w == 2) dreq_data = rnd64();
        end
        if (drop) begin
            if (w == 2) dreq_valid = 1'b0; else ireq_valid = 1'b0;
        end
        for (int k = 0; k < waits; k++) begin
            cresp_data = rnd64();
            #1;
            check("busy_iok", 64'(iresp_data_ok), 64'd0);
            check("busy_dok", 64'(dresp_data_ok), 64'd0);
            check("busy_idata", iresp_data, 64'd0);
            check("busy_ddata", dresp_data, 64'd0);
            @(posedge clk); #1;
            check("hold_addr", creq_addr, ea);
            check("hold_data", creq_data, ed);
            check("hold_grant", 64'(grant), 64'(w));
        end
        if (abort) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            last_data = 1'b0;
            check_idle_outputs("abort");
            check("abort_creq_addr", creq_addr, 64'd0);
            return;
        end
        cresp_data_ok = 1'b1;
        cresp_data    = rdata;
        #1;
        check("iresp_ok",   64'(iresp_data_ok), 64'(w == 1));
        check("dresp_ok",   64'(dresp_data_ok), 64'(w == 2));
        check("iresp_data", iresp_data, (w == 1) ? rdata : 64'd0);
        check("dresp_data", dresp_data, (w == 2) ? rdata : 64'd0);
        @(posedge clk); #1;
        cresp_data_ok = 1'b0;
        cresp_data    = rnd64();
        if (w == 2) dreq_valid = 1'b0; else ireq_valid = 1'b0;
        check_idle_outputs("done");
    endtask

    // Completion pulse with nobody holding the bus must be dropped.
    task automatic spurious();
        cresp_data_ok = 1'b1;
        cresp_data    = rnd64() | 64'd1;
        #1;
        check("spur_iok", 64'(iresp_data_ok), 64'd0);
        check("spur_dok", 64'(dresp_data_ok), 64'd0);
        check("spur_idata", iresp_data, 64'd0);
        @(posedge clk); #1;
        cresp_data_ok = 1'b0;
        check_idle_outputs("spur_after");
    endtask

    task automatic new_ireq();
        ireq_valid = 1'b1;
        ireq_addr  = rnd64();
        ireq_size  = SW'($urandom_range(0, 3));
    endtask

    task automatic new_dreq();
        dreq_valid  = 1'b1;
        dreq_addr   = rnd64();
        dreq_size   = SW'($urandom_range(0, 3));
        dreq_strobe = ($urandom_range(0, 2) == 0) ? '0 : BW'($urandom);
        dreq_data   = rnd64();
    endtask

    initial begin
        reset = 1'b1;
        ireq_valid = 0; ireq_addr = '0; ireq_size = '0;
        dreq_valid = 0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
        cresp_data_ok = 0; cresp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_creq_addr", creq_addr, 64'd0);
        reset = 1'b0;

        // Fetch alone, completion on the third busy cycle.
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0000; ireq_size = 3'd2;
        txn(2, 64'h13, 1'b0, '0, 1'b0, 1'b0);

        // Store and fetch together; store address changes mid-transaction.
        ireq_valid = 1'b1; ireq_addr = 64'h1000; ireq_size = 3'd2;
        dreq_valid = 1'b1; dreq_addr = 64'h40; dreq_size = 3'd3;
        dreq_strobe = 8'h0F; dreq_data = 64'hDEAD_BEEF;
        txn(2, 64'h55, 1'b1, 64'h80, 1'b0, 1'b0);
        txn(1, 64'h77, 1'b0, '0, 1'b0, 1'b0);

        // Reset while the data port owns the bus, then a normal request.
        new_dreq();
        txn(1, '0, 1'b0, '0, 1'b0, 1'b1);
        dreq_valid = 1'b0;
        new_ireq();
        txn(0, 64'hABCD, 1'b0, '0, 1'b0, 1'b0);

        spurious();

        // Both ports requesting continuously for four transactions.
        new_ireq(); new_dreq();
        for (int t = 0; t < 4; t++) begin
            txn(0, rnd64(), 1'b0, '0, 1'b0, 1'b0);
            if (!ireq_valid) new_ireq();
            if (!dreq_valid) new_dreq();
        end
        ireq_valid = 1'b0; dreq_valid = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            if (!ireq_valid && $urandom_range(0, 1) == 1) new_ireq();
            if (!dreq_valid && $urandom_range(0, 1) == 1) new_dreq();
            if (!ireq_valid && !dreq_valid)
                spurious();
            else
                txn($urandom_range(0, 3), rnd64(), $urandom_range(0, 1) == 1, rnd64(),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
